// File: rtl/execute_ctrl_if.sv
// Execute-stage bus: decode handshake, ALU operand/result path and memory-stage handshake.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface execute_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [31:0] valA;
  logic [31:0] valB;
  logic [31:0] valC;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_fun;
  logic [31:0] alu_vale;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] valE;
  logic        cnd;
  logic [2:0]  cc;
  logic [2:0]  stat;

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, alu_vale, out_ready,
    input  in_ready, alu_a, alu_b, alu_fun, out_valid, valE, cnd, cc, stat
  );

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, alu_vale, out_ready,
    output in_ready, alu_a, alu_b, alu_fun, out_valid, valE, cnd, cc, stat
  );
endinterface

// File: rtl/execute_ctrl.sv
// Execute-stage sequencer: IDLE -> EXEC -> DONE, HALTED on non-AOK status.
// Optional macro EXEC_OF_EN enables the overflow flag (cc[0]); otherwise OF stays 0.
module execute_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  execute_ctrl_if.slave     bus,
  output logic [1:0]        dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.
  localparam logic [31:0] STACK_STEP = 32'd8;
  localparam logic [31:0] STACK_DEC  = ~STACK_STEP + 32'd1;
  localparam logic [2:0]  STAT_AOK   = 3'd1;
  localparam logic [2:0]  STAT_HLT   = 3'd2;
  localparam logic [2:0]  STAT_INS   = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE, HALTED} state_t;

  state_t      state;
  logic [3:0]  r_icode;
  logic [3:0]  r_ifun;

  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [1:0]  sel_fun;
  logic        zf_n;
  logic        sf_n;
  logic        of_n;
  logic        lt;
  logic        cnd_n;
  logic [2:0]  stat_n;

  assign dbg_state = state;

  // Operand selection from the incoming decode fields, registered at accept.
  always_comb begin
    sel_a   = 32'd0;
    sel_b   = 32'd0;
    sel_fun = 2'd0;
    case (bus.icode)
      4'h2: sel_a = bus.valA;
      4'h3: sel_a = bus.valC;
      4'h4, 4'h5: begin
        sel_a = bus.valC;
        sel_b = bus.valB;
      end
      4'h6: begin
        sel_a   = bus.valB;
        sel_b   = bus.valA;
        sel_fun = bus.ifun[1:0];
      end
      4'h8, 4'hA: begin
        sel_a = STACK_DEC;
        sel_b = bus.valB;
      end
      4'h9, 4'hB: begin
        sel_a = STACK_STEP;
        sel_b = bus.valB;
      end
      default: ;
    endcase
  end

  // Flags from the ALU result; operands are alu_a=valB, alu_b=valA for OPl.
  always_comb begin
    zf_n = (bus.alu_vale == 32'd0);
    sf_n = bus.alu_vale[31];
`ifdef EXEC_OF_EN
    case (bus.alu_fun)
      2'd0:    of_n = (bus.alu_a[31] == bus.alu_b[31]) && (bus.alu_vale[31] != bus.alu_a[31]);
      2'd1:    of_n = (bus.alu_a[31] != bus.alu_b[31]) && (bus.alu_vale[31] != bus.alu_a[31]);
      default: of_n = 1'b0;
    endcase
`else
    of_n = 1'b0;
`endif
  end

  // Condition uses the flags as they stand before this instruction's update.
  always_comb begin
    lt    = bus.cc[1] ^ bus.cc[0];
    cnd_n = 1'b0;
    if (r_icode == 4'h2 || r_icode == 4'h7) begin
      case (r_ifun)
        4'd0:    cnd_n = 1'b1;
        4'd1:    cnd_n = lt | bus.cc[2];
        4'd2:    cnd_n = lt;
        4'd3:    cnd_n = bus.cc[2];
        4'd4:    cnd_n = ~bus.cc[2];
        4'd5:    cnd_n = ~lt;
        4'd6:    cnd_n = ~lt & ~bus.cc[2];
        default: cnd_n = 1'b0;
      endcase
    end
  end

  always_comb begin
    stat_n = STAT_AOK;
    if (r_icode == 4'h0)
      stat_n = STAT_HLT;
    else if (r_icode > 4'hB || (r_icode == 4'h6 && r_ifun > 4'd3))
      stat_n = STAT_INS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      r_icode       <= 4'd0;
      r_ifun        <= 4'd0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.valE      <= 32'd0;
      bus.cnd       <= 1'b0;
      bus.cc        <= 3'b100;
      bus.stat      <= STAT_AOK;
      bus.alu_a     <= 32'd0;
      bus.alu_b     <= 32'd0;
      bus.alu_fun   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r_icode      <= bus.icode;
            r_ifun       <= bus.ifun;
            bus.alu_a    <= sel_a;
            bus.alu_b    <= sel_b;
            bus.alu_fun  <= sel_fun;
            bus.in_ready <= 1'b0;
            state        <= EXEC;
          end
        end
        EXEC: begin
          bus.valE <= bus.alu_vale;
          bus.cnd  <= cnd_n;
          bus.stat <= stat_n;
          if (r_icode == 4'h6 && r_ifun <= 4'd3)
            bus.cc <= {zf_n, sf_n, of_n};
          bus.alu_a     <= 32'd0;
          bus.alu_b     <= 32'd0;
          bus.alu_fun   <= 2'd0;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.stat != STAT_AOK) begin
              state <= HALTED;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        HALTED: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/execute_ctrl.md
# execute_ctrl

Multi-cycle sequencer for the execute stage. Accepts one decoded instruction per handshake, drives operand selection and function code into the shared 32-bit ALU (add/sub/and/xor), captures valE, maintains the condition-code register (ZF/SF/OF) and evaluates Cnd for cmovXX/jXX. It sits between the decode stage (upstream valid/ready) and the memory stage (downstream valid/ready), and owns the only ALU instance.

## Interface
- STACK_STEP, 32'd8, stack-pointer increment for pop/ret; the decrement for push/call is its two's complement (32'hFFFFFFF8).
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  controller can accept (high only in IDLE)
- icode, ifun  in  4 each  instruction code / function
- valA, valB, valC  in  32 each  decoded operands
- alu_a, alu_b  out  32 each  ALU operands
- alu_fun  out  2  0 add, 1 sub (alu_a − alu_b), 2 and, 3 xor
- alu_vale  in  32  ALU combinational result
- out_valid  out  1  result available
- out_ready  in  1  memory stage accepts
- valE  out  32  registered ALU result
- cnd  out  1  condition outcome
- cc  out  3  {ZF,SF,OF} current register
- stat  out  3  1 AOK, 2 HLT, 4 INS

## Operation
- FSM states: IDLE, EXEC, DONE, HALTED.
- IDLE: in_ready=1; on in_valid, latch icode/ifun/valA/valB/valC -> EXEC.
- EXEC: drive ALU from latched fields; at the clock edge, capture alu_vale into valE, compute cnd, and update cc when icode=6 -> DONE.
- DONE: out_valid=1, outputs stable; on out_ready -> IDLE, or -> HALTED if stat≠AOK.
- HALTED: in_ready=0, out_valid=0; exit only by reset.
- Operand selection (alu_fun=0 unless noted):
  - 2: A=valA, B=0.
  - 3: A=valC, B=0.
  - 4, 5: A=valC, B=valB.
  - 6: A=valB, B=valA, alu_fun=ifun[1:0] (sub yields valB−valA).
  - 8, A: A=−STACK_STEP, B=valB.
  - 9, B: A=STACK_STEP, B=valB.
  - 0, 1, 7: A=B=0, valE=0.
- Outside EXEC, alu_a/alu_b/alu_fun are 0.
- Flags on OPl: ZF=(res==0); SF=res[31].
  - add: OF=(A[31]==B[31])&&(res[31]!=A[31]).
  - sub: OF=(valB[31]!=valA[31])&&(res[31]!=valB[31]).
  - and/xor: OF=0.
- cnd uses cc before this instruction's update, only for icode 2 or 7; otherwise cnd=0.
  - ifun 0: 1.
  - ifun 1: (SF^OF)|ZF.
  - ifun 2: SF^OF.
  - ifun 3: ZF.
  - ifun 4: ~ZF.
  - ifun 5: ~(SF^OF).
  - ifun 6: ~(SF^OF)&~ZF.
  - ifun ≥7: 0.
- stat: icode 0 -> HLT; icode > 4'hB or ifun>3 on icode 6 -> INS (cc not updated); else AOK.
- Arithmetic is modulo 2^32; no exceptions on overflow.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, valE=0, cnd=0, cc=3'b100 (ZF=1), stat=AOK, alu outputs 0.
- Accept at edge N -> EXEC during cycle N+1 -> out_valid from after edge N+1, held until an out_ready edge.
- Throughput is at most one instruction per 3 cycles.
- No bypass: out_ready and in_valid high together in DONE -> IDLE; the new instruction is accepted on the following edge.
- out_ready low in DONE: valE/cnd/stat/cc hold indefinitely.
- in_valid outside IDLE is ignored; the latched fields are not disturbed.
- Back-to-back OPl then cmov: cmov sees the updated cc (the update completes before the cmov's EXEC).
- Reset asserted mid-EXEC or mid-DONE: immediate return to the reset values; the in-flight instruction is discarded.

## Configuration
- EXEC_OF_EN defined: OF computed as above; cc[0] is live.
- EXEC_OF_EN undefined: OF is forced to 0 and never updated; conditions use SF^0, i.e. l=SF, le=SF|ZF.

## Test plan
- Reset then idle -> in_ready=1, cc=3'b100, out_valid=0, stat=1.
- OPl add (icode 6, ifun 0), valA=32'h7FFFFFFF, valB=1 -> valE=32'h80000000, cc={0,1,1} (OF=0 without EXEC_OF_EN), out_valid two cycles after accept.
- OPl sub, valA=5, valB=5, then jXX ifun 3 -> sub gives valE=0, cc ZF=1; jump gives cnd=1, valE=0.
- pushl (icode A), valB=32'h100 -> alu_a=32'hFFFFFFF8, valE=32'hF8; popl (icode B), valB=32'hF8 -> valE=32'h100; cc unchanged for both.
- out_ready held low 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0; next accept occurs one cycle after the out_ready handshake.
- icode 4'hF -> stat=4, then HALTED with in_ready=0; rst_n pulse low -> IDLE, cc=3'b100.
